// File: rtl/sap1_datapath.sv
// SAP-1 bus-and-register datapath.
// Holds PC, MAR, a RAM of 2**ADDR_W words, IR, A, B, an adder/subtractor and
// one shared bus. It executes the control word from the sequencer each cycle
// and returns the opcode (IR high nibble) to the sequencer.
// Ports:
//   i_clk, i_rst       rising-edge clock, synchronous active-high reset
//   i_ctrl[11:0]       HLT PC_INC PC_EN MEM_LOAD MEM_EN IR_LOAD IR_EN
//                      A_LOAD A_EN B_LOAD ADDER_SUB ADDER_EN  (bit 11..0)
//   i_prog_*           RAM program-write port (accepted in reset or halt)
//   o_opcode           IR[DATA_W-1:DATA_W-4]
//   o_a_out, o_bus     A register and live bus value
//   o_halted           sticky halt, cleared only by reset
//   o_carry, o_zero    adder flags
//   o_bus_conflict     1-cycle pulse: two or more bus drivers were enabled
//   o_prog_err         1-cycle pulse: program write rejected while running
module sap1_datapath #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 8
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic [11:0]       i_ctrl,
   input  logic              i_prog_we,
   input  logic [ADDR_W-1:0] i_prog_addr,
   input  logic [DATA_W-1:0] i_prog_data,
   output logic [3:0]        o_opcode,
   output logic [DATA_W-1:0] o_a_out,
   output logic [DATA_W-1:0] o_bus,
   output logic              o_halted,
   output logic              o_carry,
   output logic              o_zero,
   output logic              o_bus_conflict,
   output logic              o_prog_err
);

   logic [ADDR_W-1:0] r_pc;
   logic [ADDR_W-1:0] r_mar;
   logic [DATA_W-1:0] r_ir;
   logic [DATA_W-1:0] r_a;
   logic [DATA_W-1:0] r_b;
   logic              r_carry;
   logic              r_zero;
   logic              r_halted;
   logic              r_bus_conflict;
   logic              r_prog_err;
   logic [DATA_W-1:0] r_ram [2**ADDR_W];

   logic w_hlt, w_pc_inc, w_pc_en, w_mem_load, w_mem_en, w_ir_load;
   logic w_ir_en, w_a_load, w_a_en, w_b_load, w_sub, w_adder_en;

   assign w_hlt      = i_ctrl[11];
   assign w_pc_inc   = i_ctrl[10];
   assign w_pc_en    = i_ctrl[9];
   assign w_mem_load = i_ctrl[8];
   assign w_mem_en   = i_ctrl[7];
   assign w_ir_load  = i_ctrl[6];
   assign w_ir_en    = i_ctrl[5];
   assign w_a_load   = i_ctrl[4];
   assign w_a_en     = i_ctrl[3];
   assign w_b_load   = i_ctrl[2];
   assign w_sub      = i_ctrl[1];
   assign w_adder_en = i_ctrl[0];

   // Subtraction is A + ~B + 1, so carry=1 means "no borrow".
   logic [DATA_W-1:0] w_b_op;
   logic [DATA_W:0]   w_sum;
   logic [DATA_W-1:0] w_alu;
   logic              w_cout;

   assign w_b_op = w_sub ? ~r_b : r_b;
   assign w_sum  = {1'b0, r_a} + {1'b0, w_b_op} + {{DATA_W{1'b0}}, w_sub};
   assign w_alu  = w_sum[DATA_W-1:0];
   assign w_cout = w_sum[DATA_W];

   logic [DATA_W-1:0] w_bus;

   always_comb begin
      w_bus = '0;
      if (w_pc_en)         w_bus = {{(DATA_W-ADDR_W){1'b0}}, r_pc};
      else if (w_mem_en)   w_bus = r_ram[r_mar];
      else if (w_ir_en)    w_bus = {{(DATA_W-ADDR_W){1'b0}}, r_ir[ADDR_W-1:0]};
      else if (w_a_en)     w_bus = r_a;
      else if (w_adder_en) w_bus = w_alu;
   end

   logic [2:0] w_drv_cnt;
   logic       w_conflict;

   assign w_drv_cnt  = {2'b0, w_pc_en} + {2'b0, w_mem_en} + {2'b0, w_ir_en}
                     + {2'b0, w_a_en} + {2'b0, w_adder_en};
   assign w_conflict = (w_drv_cnt >= 3'd2);

   logic w_prog_ok;
   assign w_prog_ok = i_prog_we & (i_rst | r_halted);

   // RAM is deliberately left out of reset so a loaded program survives it.
   always_ff @(posedge i_clk) begin
      if (w_prog_ok) r_ram[i_prog_addr] <= i_prog_data;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_pc           <= '0;
         r_mar          <= '0;
         r_ir           <= '0;
         r_a            <= '0;
         r_b            <= '0;
         r_carry        <= 1'b0;
         r_zero         <= 1'b0;
         r_halted       <= 1'b0;
         r_bus_conflict <= 1'b0;
         r_prog_err     <= 1'b0;
      end else begin
         r_bus_conflict <= w_conflict;
         r_prog_err     <= i_prog_we & ~r_halted;
         if (!r_halted) begin
            if (w_hlt) begin
               // Halt wins over every other action in the same cycle.
               r_halted <= 1'b1;
            end else begin
               if (w_pc_inc)   r_pc  <= r_pc + ADDR_W'(1);
               if (w_mem_load) r_mar <= w_bus[ADDR_W-1:0];
               if (w_ir_load)  r_ir  <= w_bus;
               if (w_a_load)   r_a   <= w_bus;
               if (w_b_load)   r_b   <= w_bus;
               if (w_adder_en && w_a_load) begin
                  r_carry <= w_cout;
                  r_zero  <= (w_alu == '0);
               end
            end
         end
      end
   end

   assign o_opcode       = r_ir[DATA_W-1:DATA_W-4];
   assign o_a_out        = r_a;
   assign o_bus          = w_bus;
   assign o_halted       = r_halted;
   assign o_carry        = r_carry;
   assign o_zero         = r_zero;
   assign o_bus_conflict = r_bus_conflict;
   assign o_prog_err     = r_prog_err;

endmodule

// File: tb/tb_sap1_datapath.sv
// Self-checking bench for sap1_datapath: a per-cycle vector table for the
// ALU/flag/bus/conflict/program-port behaviour, then hand-written sequences
// for PC wrap, halt, full program execution and reset mid-fetch.
module tb_sap1_datapath;

   logic        clk;
   logic        rst;
   logic [11:0] ctrl;
   logic        prog_we;
   logic [3:0]  prog_addr;
   logic [7:0]  prog_data;
   logic [3:0]  opcode;
   logic [7:0]  a_out;
   logic [7:0]  bus;
   logic        halted;
   logic        carry;
   logic        zero;
   logic        bus_conflict;
   logic        prog_err;

   int checks   = 0;
   int failures = 0;

   sap1_datapath #(.ADDR_W(4), .DATA_W(8)) dut (
      .i_clk          (clk),
      .i_rst          (rst),
      .i_ctrl         (ctrl),
      .i_prog_we      (prog_we),
      .i_prog_addr    (prog_addr),
      .i_prog_data    (prog_data),
      .o_opcode       (opcode),
      .o_a_out        (a_out),
      .o_bus          (bus),
      .o_halted       (halted),
      .o_carry        (carry),
      .o_zero         (zero),
      .o_bus_conflict (bus_conflict),
      .o_prog_err     (prog_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic [11:0] ctrl;
      logic        we;
      logic [3:0]  addr;
      logic [7:0]  data;
      logic [7:0]  bus;
      logic [7:0]  a;
      logic        c;
      logic        z;
      logic        h;
      logic        conf;
      logic        perr;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(logic r, logic [11:0] c, logic we, logic [3:0] ad,
                               logic [7:0] d, logic [7:0] eb, logic [7:0] ea,
                               logic ec, logic ez, logic eh, logic ecf, logic ep);
      vec_t v;
      v.rst = r; v.ctrl = c; v.we = we; v.addr = ad; v.data = d;
      v.bus = eb; v.a = ea; v.c = ec; v.z = ez; v.h = eh; v.conf = ecf; v.perr = ep;
      return v;
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic r, input logic [11:0] c, input logic we,
                        input logic [3:0] ad, input logic [7:0] d);
      @(negedge clk);
      rst = r; ctrl = c; prog_we = we; prog_addr = ad; prog_data = d;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cyc(input logic [11:0] c);
      drive(1'b0, c, 1'b0, 4'h0, 8'h00);
      tick();
   endtask

   task automatic fetch(input int exp_op);
      cyc(12'h300);
      cyc(12'h400);
      cyc(12'h0C0);
      chk("opcode", int'(opcode), exp_op);
   endtask

   task automatic run_program(input string tag);
      fetch(0);
      cyc(12'h120); cyc(12'h090);
      chk({tag, "_lda_a"}, int'(a_out), 'h10);
      fetch(1);
      cyc(12'h120); cyc(12'h084); cyc(12'h011);
      chk({tag, "_add_a"}, int'(a_out), 'h24);
      fetch(2);
      cyc(12'h120); cyc(12'h084); cyc(12'h013);
      chk({tag, "_sub_a"}, int'(a_out), 'h0C);
      fetch(15);
      chk({tag, "_pre_halt"}, int'(halted), 0);
      cyc(12'h800);
      chk({tag, "_halted"}, int'(halted), 1);
      chk({tag, "_carry"}, int'(carry), 1);
      chk({tag, "_zero"}, int'(zero), 0);
      chk({tag, "_a_kept"}, int'(a_out), 'h0C);
   endtask

   initial begin
      rst = 1'b1; ctrl = '0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;

      // RAM 0:FF 1:01 2:03 3:05 4:05 5:5A, loaded while in reset
      tbl.push_back(mk(1, 12'h000, 1, 4'h0, 8'hFF, 8'h00, 8'h00, 0, 0, 0, 0, 0));
      tbl.push_back(mk(1, 12'h000, 1, 4'h1, 8'h01, 8'h00, 8'h00, 0, 0, 0, 0, 0));
      tbl.push_back(mk(1, 12'h000, 1, 4'h2, 8'h03, 8'h00, 8'h00, 0, 0, 0, 0, 0));
      tbl.push_back(mk(1, 12'h000, 1, 4'h3, 8'h05, 8'h00, 8'h00, 0, 0, 0, 0, 0));
      tbl.push_back(mk(1, 12'h000, 1, 4'h4, 8'h05, 8'h00, 8'h00, 0, 0, 0, 0, 0));
      tbl.push_back(mk(1, 12'h000, 1, 4'h5, 8'h5A, 8'h00, 8'h00, 0, 0, 0, 0, 0));
      // A=FF, B=01, ADD -> 00 carry zero
      tbl.push_back(mk(0, 12'h300, 0, 4'h0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 12'h490, 0, 4'h0, 8'h00, 8'hFF, 8'hFF, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 12'h300, 0, 4'h0, 8'h00, 8'h01, 8'hFF, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 12'h484, 0, 4'h0, 8'h00, 8'h01, 8'hFF, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 12'h011, 0, 4'h0, 8'h00, 8'h00, 8'h00, 1, 1, 0, 0, 0));
      // A=03, B=05, SUB -> FE borrow
      tbl.push_back(mk(0, 12'h300, 0, 4'h0, 8'h00, 8'h02, 8'h00, 1, 1, 0, 0, 0));
      tbl.push_back(mk(0, 12'h490, 0, 4'h0, 8'h00, 8'h03, 8'h03, 1, 1, 0, 0, 0));
      tbl.push_back(mk(0, 12'h300, 0, 4'h0, 8'h00, 8'h03, 8'h03, 1, 1, 0, 0, 0));
      tbl.push_back(mk(0, 12'h484, 0, 4'h0, 8'h00, 8'h05, 8'h03, 1, 1, 0, 0, 0));
      tbl.push_back(mk(0, 12'h013, 0, 4'h0, 8'h00, 8'hFE, 8'hFE, 0, 0, 0, 0, 0));
      // adder on bus without A_LOAD: FE+05 -> 03, flags must hold
      tbl.push_back(mk(0, 12'h001, 0, 4'h0, 8'h00, 8'h03, 8'hFE, 0, 0, 0, 0, 0));
      // A=05, B=05, SUB -> 00 carry zero
      tbl.push_back(mk(0, 12'h300, 0, 4'h0, 8'h00, 8'h04, 8'hFE, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 12'h490, 0, 4'h0, 8'h00, 8'h05, 8'h05, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 12'h013, 0, 4'h0, 8'h00, 8'h00, 8'h00, 1, 1, 0, 0, 0));
      // PC_EN|MEM_EN|MEM_LOAD: PC wins, MAR<=5, conflict pulse
      tbl.push_back(mk(0, 12'h380, 0, 4'h0, 8'h00, 8'h05, 8'h00, 1, 1, 0, 1, 0));
      tbl.push_back(mk(0, 12'h000, 0, 4'h0, 8'h00, 8'h00, 8'h00, 1, 1, 0, 0, 0));
      tbl.push_back(mk(0, 12'h080, 0, 4'h0, 8'h00, 8'h5A, 8'h00, 1, 1, 0, 0, 0));
      // MEM_EN over A_EN
      tbl.push_back(mk(0, 12'h088, 0, 4'h0, 8'h00, 8'h5A, 8'h00, 1, 1, 0, 1, 0));
      // write while running: dropped, error pulse
      tbl.push_back(mk(0, 12'h000, 1, 4'h5, 8'h77, 8'h00, 8'h00, 1, 1, 0, 0, 1));
      tbl.push_back(mk(0, 12'h080, 0, 4'h0, 8'h00, 8'h5A, 8'h00, 1, 1, 0, 0, 0));

      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i].rst, tbl[i].ctrl, tbl[i].we, tbl[i].addr, tbl[i].data);
         chk($sformatf("v%0d_bus", i), int'(bus), int'(tbl[i].bus));
         tick();
         chk($sformatf("v%0d_a", i), int'(a_out), int'(tbl[i].a));
         chk($sformatf("v%0d_carry", i), int'(carry), int'(tbl[i].c));
         chk($sformatf("v%0d_zero", i), int'(zero), int'(tbl[i].z));
         chk($sformatf("v%0d_halted", i), int'(halted), int'(tbl[i].h));
         chk($sformatf("v%0d_conflict", i), int'(bus_conflict), int'(tbl[i].conf));
         chk($sformatf("v%0d_prog_err", i), int'(prog_err), int'(tbl[i].perr));
      end

      // PC wrap: PC is 5 here; 10 increments reach F, one more wraps to 0
      for (int i = 0; i < 10; i++) cyc(12'h400);
      drive(1'b0, 12'h200, 1'b0, 4'h0, 8'h00);
      chk("pc_f", int'(bus), 'h0F);
      tick();
      drive(1'b0, 12'h600, 1'b0, 4'h0, 8'h00);
      chk("pc_en_inc_old", int'(bus), 'h0F);
      tick();
      drive(1'b0, 12'h200, 1'b0, 4'h0, 8'h00);
      chk("pc_wrap", int'(bus), 'h00);
      tick();

      // Halt with PC_INC and A_LOAD in the same cycle
      drive(1'b0, 12'hC90, 1'b0, 4'h0, 8'h00);
      chk("halt_bus", int'(bus), 'h5A);
      tick();
      chk("halt_set", int'(halted), 1);
      chk("halt_a_kept", int'(a_out), 'h00);
      drive(1'b0, 12'h200, 1'b0, 4'h0, 8'h00);
      chk("halt_pc_kept", int'(bus), 'h00);
      tick();
      drive(1'b0, 12'h1D4, 1'b1, 4'h6, 8'h66);
      chk("halted_bus_drive", int'(bus), 'h5A);
      tick();
      chk("halted_a_ignored", int'(a_out), 'h00);
      chk("halted_write_ok", int'(prog_err), 0);
      chk("halt_sticky", int'(halted), 1);
      drive(1'b0, 12'h080, 1'b0, 4'h0, 8'h00);
      chk("halted_mar_kept", int'(bus), 'h5A);
      tick();

      // Program load under reset, then full run
      drive(1'b1, 12'h000, 1'b1, 4'h0, 8'h09); tick();
      chk("rst_halt_clr", int'(halted), 0);
      chk("rst_a_clr", int'(a_out), 0);
      drive(1'b1, 12'h000, 1'b1, 4'h1, 8'h1A); tick();
      drive(1'b1, 12'h000, 1'b1, 4'h2, 8'h2B); tick();
      drive(1'b1, 12'h000, 1'b1, 4'h3, 8'hF0); tick();
      drive(1'b1, 12'h000, 1'b1, 4'h9, 8'h10); tick();
      drive(1'b1, 12'h000, 1'b1, 4'hA, 8'h14); tick();
      drive(1'b1, 12'h000, 1'b1, 4'hB, 8'h18); tick();
      chk("rst_flags_c", int'(carry), 0);
      chk("rst_flags_z", int'(zero), 0);
      run_program("run1");

      // Reset mid-fetch: RAM survives, registers clear, rerun matches
      drive(1'b1, 12'h000, 1'b0, 4'h0, 8'h00); tick();
      fetch(0);
      cyc(12'h120); cyc(12'h090);
      chk("mid_lda_a", int'(a_out), 'h10);
      cyc(12'h300);
      cyc(12'h400);
      drive(1'b1, 12'h0C0, 1'b0, 4'h0, 8'h00); tick();
      chk("mid_rst_a", int'(a_out), 0);
      chk("mid_rst_op", int'(opcode), 0);
      drive(1'b0, 12'h020, 1'b0, 4'h0, 8'h00);
      chk("mid_rst_ir", int'(bus), 0);
      tick();
      drive(1'b0, 12'h200, 1'b0, 4'h0, 8'h00);
      chk("mid_rst_pc", int'(bus), 0);
      tick();
      run_program("run2");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
